// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor using restoring
// shift-subtract on magnitudes, with the signs applied in a final SIGN step.
module booth_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DW - 1);
    localparam logic [DW-1:0] Q_NEG_MAX = {{(DW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DW-1:0] Q_POS_MAX = Q_NEG_MAX - {{(DW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    // -2^(2W-1) maps onto itself, which read as unsigned is the correct magnitude
    function automatic logic [DW-1:0] mag_dw(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + {{(DW-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + ONE_W) : x;
    endfunction

    state_t            state_r;
    logic [WIDTH-1:0]  rem_r;
    logic [DW-1:0]     quo_r;
    logic [WIDTH-1:0]  dvs_r;
    logic [CW-1:0]     cnt_r;
    logic              dvd_neg_r;
    logic              dvs_neg_r;
    logic              dbz_r;

    logic [WIDTH:0]    rem_sh_s;
    logic [DW-1:0]     quo_sh_s;
    logic [WIDTH-1:0]  rem_nxt_s;
    logic [DW-1:0]     quo_nxt_s;
    logic              q_neg_s;
    logic [WIDTH-1:0]  q_low_s;
    logic [WIDTH-1:0]  r_signed_s;
    logic              ovf_s;

    // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
    // The difference is below |divisor| so the W-bit modular subtract is exact.
    always_comb begin
        rem_sh_s  = {rem_r, quo_r[DW-1]};
        quo_sh_s  = {quo_r[DW-2:0], 1'b0};
        rem_nxt_s = rem_sh_s[WIDTH-1:0];
        quo_nxt_s = quo_sh_s;
        if (rem_sh_s >= {1'b0, dvs_r}) begin
            rem_nxt_s = rem_sh_s[WIDTH-1:0] - dvs_r;
            quo_nxt_s = quo_sh_s | {{(DW-1){1'b0}}, 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[WIDTH-1:0];
            quo_nxt_s = quo_sh_s;
        end
    end

    // Sign application and range check on the unsigned quotient magnitude
    always_comb begin
        q_neg_s    = dvd_neg_r ^ dvs_neg_r;
        q_low_s    = quo_r[WIDTH-1:0];
        r_signed_s = rem_r;
        ovf_s      = 1'b0;
        if (q_neg_s) begin
            q_low_s = ~quo_r[WIDTH-1:0] + ONE_W;
            ovf_s   = (quo_r > Q_NEG_MAX);
        end else begin
            q_low_s = quo_r[WIDTH-1:0];
            ovf_s   = (quo_r > Q_POS_MAX);
        end
        if (dvd_neg_r) begin
            r_signed_s = ~rem_r + ONE_W;
        end else begin
            r_signed_s = rem_r;
        end
    end

    // Control FSM, datapath registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {DW{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        rem_r     <= {WIDTH{1'b0}};
                        cnt_r     <= {CW{1'b0}};
                        dvd_neg_r <= dividend[DW-1];
                        dvs_neg_r <= divisor[WIDTH-1];
                        dvs_r     <= mag_w(divisor);
                        if (divisor == {WIDTH{1'b0}}) begin
                            // raw dividend kept so SIGN can return its low half
                            dbz_r   <= 1'b1;
                            quo_r   <= dividend;
                            state_r <= SIGN;
                        end else begin
                            dbz_r   <= 1'b0;
                            quo_r   <= mag_dw(dividend);
                            state_r <= CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= SIGN;
                    end else begin
                        state_r <= CALC;
                    end
                end
                SIGN: begin
                    done    <= 1'b1;
                    state_r <= IDLE;
                    if (dbz_r) begin
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= quo_r[WIDTH-1:0];
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= q_low_s;
                        remainder   <= r_signed_s;
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Randomized self-checking bench for booth_divider against a plain-arithmetic
// signed division model (truncating quotient, remainder following the dividend).
module tb_booth_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          prev_done = 1'b0;
    logic [15:0] last_q = 16'h0000;

    booth_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // chain: start is raised in the done cycle of the previous divide
    // inject: a foreign start with other operands is pulsed mid-calculation
    task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                           input bit chain, input bit inject);
        longint      sa, sb, q, r;
        logic [15:0] eq, er;
        logic        eovf, edbz;
        int          k, elat;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 64'sd0) begin
            eq = 16'hFFFF; er = a[15:0]; eovf = 1'b0; edbz = 1'b1; elat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            eq = q[15:0]; er = r[15:0];
            eovf = (q < -64'sd32768) || (q > 64'sd32767);
            edbz = 1'b0; elat = 33;
        end
        if (!chain) begin
            @(negedge clk);
            if (prev_done) begin
                check("busy_fall", {63'd0, busy}, 64'd0);
                check("done_pulse", {63'd0, done}, 64'd0);
                check("hold_q", {48'd0, quotient}, {48'd0, last_q});
            end
        end
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        check("busy_hi", {63'd0, busy}, 64'd1);
        k = 0;
        while (done !== 1'b1 && k < 80) begin
            if (inject && k == 5) begin
                start = 1'b1; dividend = $urandom; divisor = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("latency", 64'(k), 64'(elat));
        check("quotient", {48'd0, quotient}, {48'd0, eq});
        check("remainder", {48'd0, remainder}, {48'd0, er});
        check("overflow", {63'd0, overflow}, {63'd0, eovf});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, edbz});
        check("busy_at_done", {63'd0, busy}, 64'd1);
        last_q    = eq;
        prev_done = 1'b1;
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_q", {48'd0, quotient}, 64'd0);
        check("rst_r", {48'd0, remainder}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;

        run_div(32'd1000, 16'd7, 1'b0, 1'b0);
        run_div(-32'sd1000, 16'd7, 1'b0, 1'b0);
        run_div(32'd1000, -16'sd7, 1'b0, 1'b0);
        run_div(-32'sd1000, -16'sd7, 1'b0, 1'b0);
        run_div(32'h4000_0000, 16'd2, 1'b0, 1'b0);
        run_div(-32'sd32768, 16'd1, 1'b0, 1'b0);
        run_div(32'h8000_0000, 16'hFFFF, 1'b0, 1'b0);
        run_div(32'h8000_0000, 16'h8000, 1'b0, 1'b0);
        run_div(32'd1234, 16'd0, 1'b0, 1'b0);
        run_div(32'd100, 16'd3, 1'b1, 1'b0);
        run_div(-32'sd5000, 16'd9, 1'b0, 1'b1);
        run_div(32'h7FFF_FFFF, 16'h7FFF, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ra = {{8{ra[23]}}, ra[23:0]};
                1: rb = {{12{rb[3]}}, rb[3:0]};
                2: ra = {{16{ra[15]}}, ra[15:0]};
                default: ra = ra;
            endcase
            run_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // abort a divide part-way through with reset
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_q", {48'd0, quotient}, 64'd0);
        check("abort_r", {48'd0, remainder}, 64'd0);
        check("abort_ovf", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        prev_done = 1'b0;
        run_div(32'd1000, 16'd7, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
